// File: rtl/sap_pkg.sv
// sap_pkg: control-word layout, opcodes and default widths shared by the SAP sequencer and datapath.
package sap_pkg;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 4;

    typedef struct packed {
        logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    } ctrl_t;

    localparam logic [15:0] CW_HLT = 16'h8000;
    localparam logic [15:0] CW_MI  = 16'h4000;
    localparam logic [15:0] CW_RI  = 16'h2000;
    localparam logic [15:0] CW_RO  = 16'h1000;
    localparam logic [15:0] CW_IO  = 16'h0800;
    localparam logic [15:0] CW_II  = 16'h0400;
    localparam logic [15:0] CW_AI  = 16'h0200;
    localparam logic [15:0] CW_AO  = 16'h0100;
    localparam logic [15:0] CW_EO  = 16'h0080;
    localparam logic [15:0] CW_SU  = 16'h0040;
    localparam logic [15:0] CW_BI  = 16'h0020;
    localparam logic [15:0] CW_OI  = 16'h0010;
    localparam logic [15:0] CW_CE  = 16'h0008;
    localparam logic [15:0] CW_CO  = 16'h0004;
    localparam logic [15:0] CW_J   = 16'h0002;
    localparam logic [15:0] CW_FI  = 16'h0001;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
        OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_t;
endpackage

// File: rtl/sap_datapath_if.sv
// sap_datapath_if: control word, program-load port and status returned by the SAP datapath.
interface sap_datapath_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic [15:0]       ctrl_data;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [WIDTH-1:0]  load_data;
    logic [3:0]        instruction;
    logic              flag_c;
    logic              flag_z;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              halted;
    logic              bus_conflict;

    modport master (
        output ctrl_data, load_en, load_addr, load_data,
        input  instruction, flag_c, flag_z, out_data, out_valid, halted, bus_conflict
    );
    modport slave (
        input  ctrl_data, load_en, load_addr, load_data,
        output instruction, flag_c, flag_z, out_data, out_valid, halted, bus_conflict
    );
endinterface

// File: rtl/sap_alu.sv
// sap_alu: combinational add/subtract with carry-out and zero detect.
module sap_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             su_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o
);
    logic [WIDTH:0] sum;
    assign sum      = {1'b0, a_i} + {1'b0, su_i ? ~b_i : b_i} + {{WIDTH{1'b0}}, su_i};
    assign result_o = sum[WIDTH-1:0];
    assign carry_o  = sum[WIDTH];
    assign zero_o   = (sum[WIDTH-1:0] == '0);
endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 style datapath applying one microcode control word per clock.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic           clk,
    input logic           rst,
    sap_datapath_if.slave bus_if
);
    ctrl_t             c;
    logic [WIDTH-1:0]  a_q, b_q, ir_q, out_q, bus, alu_r;
    logic [WIDTH-1:0]  ram_q [2**ADDR_W];
    logic [ADDR_W-1:0] mar_q, pc_q, pc_d;
    logic              fc_q, fz_q, ov_q, halted_q, conflict_q;
    logic              alu_c, alu_z, act, multi;

    assign c     = ctrl_t'(bus_if.ctrl_data);
    assign act   = !halted_q && !bus_if.load_en;
    assign multi = $countones({c.ro, c.io, c.ao, c.eo, c.co}) > 1;
    // Simultaneous drivers are ORed, matching an open-collector style bus.
    assign bus   = (c.ro ? ram_q[mar_q] : '0)
                 | (c.io ? WIDTH'(ir_q[3:0]) : '0)
                 | (c.ao ? a_q : '0)
                 | (c.eo ? alu_r : '0)
                 | (c.co ? WIDTH'(pc_q) : '0);
    assign pc_d  = c.j ? bus[ADDR_W-1:0] : c.ce ? pc_q + ADDR_W'(1) : pc_q;

    sap_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .su_i     (c.su),
        .result_o (alu_r),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            ir_q       <= '0;
            out_q      <= '0;
            mar_q      <= '0;
            pc_q       <= '0;
            fc_q       <= 1'b0;
            fz_q       <= 1'b0;
            ov_q       <= 1'b0;
            halted_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            ov_q <= act && c.oi;
            if (act) begin
                if (c.mi) mar_q <= bus[ADDR_W-1:0];
                if (c.ii) ir_q <= bus;
                if (c.ai) a_q <= bus;
                if (c.bi) b_q <= bus;
                if (c.oi) out_q <= bus;
                if (c.fi) {fc_q, fz_q} <= {alu_c, alu_z};
                if (c.hlt) halted_q <= 1'b1;
                if (multi) conflict_q <= 1'b1;
                pc_q <= pc_d;
            end
        end

    // RAM is not reset; RI uses the pre-edge MAR even when MI fires too.
    always_ff @(posedge clk)
        if (bus_if.load_en) ram_q[bus_if.load_addr] <= bus_if.load_data;
        else if (!rst && act && c.ri) ram_q[mar_q] <= bus;

    assign bus_if.instruction  = ir_q[WIDTH-1:WIDTH-4];
    assign bus_if.flag_c       = fc_q;
    assign bus_if.flag_z       = fz_q;
    assign bus_if.out_data     = out_q;
    assign bus_if.out_valid    = ov_q;
    assign bus_if.halted       = halted_q;
    assign bus_if.bus_conflict = conflict_q;
endmodule
